// File: rtl/clock_step_ctrl_pkg.sv
// Shared processor clock-control types: FSM state encoding and default debounce depth.
// Pure declarations; no latency, no flow control.
package clock_step_ctrl_pkg;

  localparam int DEBOUNCE_CYCLES_DEF = 4;

  typedef enum logic [1:0] {
    RUN           = 2'd0,
    STEP_IDLE     = 2'd1,
    STEP_PULSE    = 2'd2,
    STEP_WAIT_REL = 2'd3
  } step_state_t;

  function automatic logic is_step_state(input step_state_t s);
    return s != RUN;
  endfunction

endpackage

// File: rtl/clock_step_ctrl_step_debounce.sv
// Button synchronizer and debouncer; level follows input after 2 + DEBOUNCE_CYCLES clean cycles.
// rise is a registered one-cycle pulse on each accepted 0->1 change; no backpressure.
module step_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          raw_s1;
  logic          raw_s2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      raw_s1 <= 1'b0;
      raw_s2 <= 1'b0;
      level  <= 1'b0;
      rise   <= 1'b0;
      cnt    <= '0;
    end else begin
      raw_s1 <= raw;
      raw_s2 <= raw_s1;
      rise   <= 1'b0;
      // Any cycle agreeing with the accepted level restarts the stability window.
      if (raw_s2 == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        level <= raw_s2;
        rise  <= raw_s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/clock_step_ctrl.sv
// Free-run / single-step clock enable for the processor; cpu_en registered, enable lands 1 cycle after FSM decision.
// One enabled cycle per debounced press in step mode; halt forces stall; no backpressure.
module clock_step_ctrl
  import clock_step_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_step,
  input  logic             clk_select,
  input  logic             halt,
  output logic             cpu_en,
  output logic             step_mode,
  output logic [CNT_W-1:0] cycle_count
);

  step_state_t state;
  step_state_t next_state;
  logic        sel_s1;
  logic        sel_s2;
  logic        armed;
  logic        step_level;
  logic        step_rise;
  logic        cpu_en_nxt;
  logic        step_mode_nxt;

  step_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_step_debounce (
    .clk  (clk),
    .rst  (rst),
    .raw  (clk_step),
    .level(step_level),
    .rise (step_rise)
  );

  // armed holds off enables until the second edge after reset release.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= RUN;
      sel_s1      <= 1'b0;
      sel_s2      <= 1'b0;
      armed       <= 1'b0;
      cpu_en      <= 1'b0;
      step_mode   <= 1'b0;
      cycle_count <= '0;
    end else begin
      state     <= next_state;
      sel_s1    <= clk_select;
      sel_s2    <= sel_s1;
      armed     <= 1'b1;
      cpu_en    <= cpu_en_nxt;
      step_mode <= step_mode_nxt;
      if (cpu_en_nxt && (cycle_count != {CNT_W{1'b1}})) begin
        cycle_count <= cycle_count + 1'b1;
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      RUN: begin
        if (sel_s2) next_state = STEP_IDLE;
      end
      STEP_IDLE: begin
        // Leaving step mode beats a coincident step request.
        if (!sel_s2)        next_state = RUN;
        else if (step_rise) next_state = STEP_PULSE;
      end
      STEP_PULSE: begin
        next_state = STEP_WAIT_REL;
      end
      STEP_WAIT_REL: begin
        if (!step_level) next_state = STEP_IDLE;
      end
      default: begin
        next_state = RUN;
      end
    endcase
  end

  // Outputs are decoded from next_state so the registered copies line up with state.
  always_comb begin
    cpu_en_nxt    = armed && !halt &&
                    ((next_state == RUN) || (next_state == STEP_PULSE));
    step_mode_nxt = is_step_state(next_state);
  end

endmodule

// File: tb/tb_clock_step_ctrl.sv
// Directed bench for clock_step_ctrl: vector table for run/step sequences plus hand-written corner cases.
// Second instance with CNT_W=4 shares stimulus to observe counter saturation.
module tb_clock_step_ctrl;
  import clock_step_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clk_step = 1'b0;
  logic        clk_select = 1'b0;
  logic        halt = 1'b0;
  logic        cpu_en;
  logic        step_mode;
  logic [31:0] cycle_count;
  logic        cpu_en4;
  logic        step_mode4;
  logic [3:0]  cycle_count4;

  int errors = 0;
  int checks = 0;
  int pulses = 0;
  int pulses4 = 0;

  always #5 clk = ~clk;

  clock_step_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .clk_step   (clk_step),
    .clk_select (clk_select),
    .halt       (halt),
    .cpu_en     (cpu_en),
    .step_mode  (step_mode),
    .cycle_count(cycle_count)
  );

  clock_step_ctrl #(.CNT_W(4)) dut4 (
    .clk        (clk),
    .rst        (rst),
    .clk_step   (clk_step),
    .clk_select (clk_select),
    .halt       (halt),
    .cpu_en     (cpu_en4),
    .step_mode  (step_mode4),
    .cycle_count(cycle_count4)
  );

  typedef struct {
    string name;
    logic  rst_v;
    logic  sel_v;
    logic  step_v;
    logic  halt_v;
    int    n;
    int    exp_pulses;
    logic  exp_mode;
    int    exp_cnt;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input longint act, input longint lo, input longint hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Advance one edge, sample 1 time unit later, tally enabled cycles.
  task automatic tick();
    @(posedge clk);
    #1;
    if (cpu_en)  pulses++;
    if (cpu_en4) pulses4++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int first_idx;
    int cnt_base;

    vecs[0]  = '{"reset",        1'b0, 1'b0, 1'b0, 1'b0,   3,  0, 1'b0,   0};
    vecs[1]  = '{"free_run",     1'b1, 1'b0, 1'b0, 1'b0, 100, 99, 1'b0,  99};
    vecs[2]  = '{"enter_step",   1'b1, 1'b1, 1'b0, 1'b0,   5,  2, 1'b1, 101};
    vecs[3]  = '{"glitch_3cyc",  1'b1, 1'b1, 1'b1, 1'b0,   3,  0, 1'b1, 101};
    vecs[4]  = '{"glitch_after", 1'b1, 1'b1, 1'b0, 1'b0,  20,  0, 1'b1, 101};
    vecs[5]  = '{"press1",       1'b1, 1'b1, 1'b1, 1'b0,  10,  1, 1'b1, 102};
    vecs[6]  = '{"release1",     1'b1, 1'b1, 1'b0, 1'b0,  20,  0, 1'b1, 102};
    vecs[7]  = '{"press2",       1'b1, 1'b1, 1'b1, 1'b0,  10,  1, 1'b1, 103};
    vecs[8]  = '{"release2",     1'b1, 1'b1, 1'b0, 1'b0,  20,  0, 1'b1, 103};
    vecs[9]  = '{"press3",       1'b1, 1'b1, 1'b1, 1'b0,  10,  1, 1'b1, 104};
    vecs[10] = '{"release3",     1'b1, 1'b1, 1'b0, 1'b0,  20,  0, 1'b1, 104};

    #1;
    for (int v = 0; v < 11; v++) begin
      rst        = vecs[v].rst_v;
      clk_select = vecs[v].sel_v;
      clk_step   = vecs[v].step_v;
      halt       = vecs[v].halt_v;
      pulses  = 0;
      pulses4 = 0;
      ticks(vecs[v].n);
      check({vecs[v].name, "_pulses"}, pulses, vecs[v].exp_pulses);
      check({vecs[v].name, "_pulses4"}, pulses4, vecs[v].exp_pulses);
      check({vecs[v].name, "_mode"}, step_mode, vecs[v].exp_mode);
      check({vecs[v].name, "_cnt"}, cycle_count, vecs[v].exp_cnt);
      check({vecs[v].name, "_cnt4"}, cycle_count4,
            (vecs[v].exp_cnt > 15) ? 15 : vecs[v].exp_cnt);
    end

    // Held button: one enabled cycle at about 7 cycles after the press.
    first_idx = -1;
    pulses = 0;
    clk_step = 1'b1;
    for (int i = 1; i <= 50; i++) begin
      tick();
      if (cpu_en && first_idx < 0) first_idx = i;
    end
    check_range("hold_latency", first_idx, 6, 8);
    check("hold_pulses", pulses, 1);
    check("hold_cnt", cycle_count, 105);
    clk_step = 1'b0;
    ticks(20);

    // Step while halted is consumed without enabling.
    halt = 1'b1;
    clk_step = 1'b1;
    pulses = 0;
    ticks(10);
    check("halt_pulses", pulses, 0);
    check("halt_state", dut.state, STEP_WAIT_REL);
    check("halt_cnt", cycle_count, 105);
    clk_step = 1'b0;
    ticks(20);
    halt = 1'b0;
    ticks(2);

    // Select dropped while button held: stall until release, then run.
    clk_step = 1'b1;
    pulses = 0;
    ticks(10);
    check("sel_hold_pulse", pulses, 1);
    clk_select = 1'b0;
    pulses = 0;
    ticks(10);
    check("sel_hold_stall", pulses, 0);
    check("sel_hold_mode", step_mode, 1);
    check("sel_hold_state", dut.state, STEP_WAIT_REL);
    clk_step = 1'b0;
    first_idx = -1;
    for (int i = 1; i <= 20 && first_idx < 0; i++) begin
      tick();
      if (cpu_en) first_idx = i;
    end
    check_range("release_to_run", first_idx, 7, 9);
    check("release_mode", step_mode, 0);

    // Reset asserted while in STEP_PULSE.
    clk_select = 1'b1;
    ticks(6);
    check("pre_pulse_mode", step_mode, 1);
    cnt_base = int'(cycle_count);
    clk_step = 1'b1;
    for (int i = 0; i < 20 && !cpu_en; i++) tick();
    check("pulse_reached", cpu_en, 1);
    check("pulse_state", dut.state, STEP_PULSE);
    check("pulse_cnt", cycle_count, cnt_base + 1);
    rst = 1'b0;
    clk_step = 1'b0;
    clk_select = 1'b0;
    tick();
    check("rst_pulse_en", cpu_en, 0);
    check("rst_pulse_mode", step_mode, 0);
    check("rst_pulse_cnt", cycle_count, 0);
    check("rst_pulse_cnt4", cycle_count4, 0);
    rst = 1'b1;
    tick();
    check("post_rst_edge1", cpu_en, 0);
    tick();
    check("post_rst_edge2", cpu_en, 1);
    check("post_rst_cnt", cycle_count, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
